// File: rtl/share_recombine_byteswap.sv
// Registered output adapter: XOR-recombines a D-share masked bus into one word,
// optionally reverses it in WIDTH-bit groups, and presents it behind valid/ready.
module share_recombine_byteswap #(
    parameter int D       = 2,
    parameter int BSIZE   = 128,
    parameter int WIDTH   = 8,
    parameter bit REVERSE = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BSIZE*D-1:0]   in_shares,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BSIZE-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int GROUPS = BSIZE / WIDTH;

    generate
        if (D < 1 || (BSIZE % WIDTH) != 0) begin : g_param_check
            $error("share_recombine_byteswap: need D >= 1 and BSIZE a multiple of WIDTH");
        end
    endgenerate

    logic [BSIZE-1:0] recombined;
    logic [BSIZE-1:0] shaped;

    // NOTE: give every always_comb output a default before the loop, or a latch is inferred.
    always_comb begin
        recombined = '0;
        for (int s = 0; s < D; s++) begin
            recombined ^= in_shares[BSIZE*s +: BSIZE];
        end
    end

    // Group reversal is pure wiring; bit order inside each group is preserved.
    generate
        if (REVERSE) begin : g_reverse
            for (genvar g = 0; g < GROUPS; g++) begin : g_group
                assign shaped[WIDTH*g +: WIDTH] = recombined[BSIZE-WIDTH*(g+1) +: WIDTH];
            end
        end else begin : g_passthru
            assign shaped = recombined;
        end
    endgenerate

    // The single entry may be refilled on the same edge it drains, so no bubble.
    assign in_ready = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= shaped;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_share_recombine_byteswap.sv
// Randomized bench for share_recombine_byteswap: one-entry buffer model plus an
// in-order scoreboard, with side instances for the D=3 and D=1 configurations.
module tb_share_recombine_byteswap;

    localparam int BSIZE = 128;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main instance: D=2, REVERSE=1
    logic [2*BSIZE-1:0] in_shares;
    logic               in_valid, in_ready, out_valid, out_ready;
    logic [BSIZE-1:0]   out_data;

    share_recombine_byteswap #(.D(2), .BSIZE(BSIZE), .WIDTH(8), .REVERSE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_shares(in_shares), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    // D=3, REVERSE=0
    logic [3*BSIZE-1:0] sh3;
    logic               v3, rdy3, ov3, ordy3;
    logic [BSIZE-1:0]   od3;

    share_recombine_byteswap #(.D(3), .BSIZE(BSIZE), .WIDTH(8), .REVERSE(1'b0)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_shares(sh3), .in_valid(v3),
        .in_ready(rdy3), .out_data(od3), .out_valid(ov3), .out_ready(ordy3)
    );

    // D=1, REVERSE=1
    logic [BSIZE-1:0]   sh1;
    logic               v1, rdy1, ov1, ordy1;
    logic [BSIZE-1:0]   od1;

    share_recombine_byteswap #(.D(1), .BSIZE(BSIZE), .WIDTH(8), .REVERSE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_shares(sh1), .in_valid(v1),
        .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(ordy1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [BSIZE-1:0] act, input logic [BSIZE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [BSIZE-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [BSIZE-1:0] bswap(input logic [BSIZE-1:0] r);
        logic [BSIZE-1:0] o;
        o = {<<8{r}};
        return o;
    endfunction

    // Reference: the unmasked value is the XOR of the two shares, then byte-reversed.
    function automatic logic [BSIZE-1:0] ref_word(input logic [2*BSIZE-1:0] sh);
        return bswap(sh[BSIZE-1:0] ^ sh[2*BSIZE-1:BSIZE]);
    endfunction

    // Behavioural model of the one-entry buffer and a queue of words owed downstream.
    logic             m_valid;
    logic [BSIZE-1:0] m_data;
    logic [BSIZE-1:0] exp_q[$];
    int               sent, delivered;

    // Called shortly after a rising edge with inputs already applied.
    task automatic cycle(input string tag);
        logic exp_rdy;
        logic acc;
        #1;
        exp_rdy = !m_valid || out_ready;
        check({tag, "_in_ready"}, BSIZE'(in_ready), BSIZE'(exp_rdy));
        acc = in_valid && exp_rdy;
        if (m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check({tag, "_underflow"}, BSIZE'(out_valid), '0);
            end else begin
                check({tag, "_order"}, out_data, exp_q.pop_front());
                delivered++;
            end
        end
        @(posedge clk);
        if (acc) begin
            m_data  = ref_word(in_shares);
            m_valid = 1'b1;
            exp_q.push_back(m_data);
            sent++;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
        check({tag, "_out_valid"}, BSIZE'(out_valid), BSIZE'(m_valid));
        if (m_valid) check({tag, "_out_data"}, out_data, m_data);
    endtask

    function automatic logic [2*BSIZE-1:0] rand_shares();
        return {rand_word(), rand_word()};
    endfunction

    initial begin
        logic [BSIZE-1:0] a, m, held, x0, x1, x2;
        logic [2*BSIZE-1:0] next_sh;

        rst_n = 1'b0;
        in_shares = '0; in_valid = 1'b0; out_ready = 1'b1;
        sh3 = '0; v3 = 1'b0; ordy3 = 1'b1;
        sh1 = '0; v1 = 1'b0; ordy1 = 1'b1;
        m_valid = 1'b0; m_data = '0; sent = 0; delivered = 0;

        // Reset state
        #12;
        check("rst_out_valid", BSIZE'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_in_ready", BSIZE'(in_ready), BSIZE'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);

        // Directed byte-swap vector with a zero second share
        in_shares = {128'h0, 128'h3925841d02dc09fbdc118597196a0b32};
        in_valid = 1'b1;
        cycle("vec");
        check("vec_const", out_data, 128'h320b6a19978511dcfb09dc021d842539);

        // Equal shares cancel; a masked pair recovers the swapped secret
        a = rand_word();
        in_shares = {a, a};
        cycle("cancel");
        check("cancel_zero", out_data, '0);
        m = rand_word();
        in_shares = {m, a ^ m};
        cycle("mask");
        check("mask_swap", out_data, bswap(a));

        // Backpressure: a held word stays put while new inputs are offered
        held = m_data;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_shares = rand_shares();
            cycle("hold");
            check("hold_stable", out_data, held);
        end
        next_sh = rand_shares();
        in_shares = next_sh;
        out_ready = 1'b1;
        cycle("release");
        check("release_load", out_data, ref_word(next_sh));

        // Stream of 100 words at full rate
        sent = 0; delivered = 0;
        in_valid = 1'b0;
        cycle("flush");
        delivered = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_shares = rand_shares();
            cycle("stream");
        end
        in_valid = 1'b0;
        cycle("stream_tail");
        check("stream_sent", BSIZE'(sent), BSIZE'(100));
        check("stream_delivered", BSIZE'(delivered), BSIZE'(100));

        // Random valid and ready
        for (int i = 0; i < 300; i++) begin
            in_shares = rand_shares();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle("rand_drain");
        check("rand_queue_empty", BSIZE'(exp_q.size()), '0);

        // Asynchronous reset between edges while a word is held
        in_shares = rand_shares();
        in_valid = 1'b1;
        out_ready = 1'b0;
        cycle("pre_rst");
        check("pre_rst_valid", BSIZE'(out_valid), BSIZE'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", BSIZE'(out_valid), '0);
        check("async_rst_data", out_data, '0);
        m_valid = 1'b0;
        exp_q.delete();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        next_sh = rand_shares();
        in_shares = next_sh;
        in_valid = 1'b1;
        cycle("post_rst");
        check("post_rst_word", out_data, ref_word(next_sh));
        in_valid = 1'b0;
        cycle("post_rst_idle");

        // D=3 without reversal, D=1 with reversal
        for (int i = 0; i < 6; i++) begin
            x0 = rand_word(); x1 = rand_word(); x2 = rand_word();
            sh3 = {x2, x1, x0};
            sh1 = x0;
            v3 = 1'b1;
            v1 = 1'b1;
            @(posedge clk);
            #1;
            v3 = 1'b0;
            v1 = 1'b0;
            check("d3_valid", BSIZE'(ov3), BSIZE'(1'b1));
            check("d3_xor", od3, x0 ^ x1 ^ x2);
            check("d1_valid", BSIZE'(ov1), BSIZE'(1'b1));
            check("d1_swap", od1, bswap(x0));
            sh3 = '1;
            sh1 = '1;
            @(posedge clk);
            #1;
            check("d3_drained", BSIZE'(ov3), '0);
            check("d1_drained", BSIZE'(ov1), '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
